nrzi_dec: RTL



---
 rtl/nrzi_dec_pkg.sv | 25 ++
 rtl/nrzi_dec_if.sv | 37 +++
 rtl/nrzi_unstuff.sv | 44 ++++
 rtl/nrzi_dec.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/nrzi_dec_pkg.sv
// nrzi_pkg: shared types and constants for the NRZI receive decoder.
//   nrzi_dec_state_t : decoder FSM states (IDLE, SYNC, DATA, ERR)
//   nrzi_err_t       : err_code values (NONE, SYNC, STUFF, OVF)
//   SYNC_LEN         : SYNC field length in bits (7 zeros then a 1)
//   STUFF_RUN        : run of 1s after which a stuffed 0 is expected
//   UNSTUFF_W        : width of the saturating stuffed-bit counter
package nrzi_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } nrzi_dec_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SYNC  = 2'd1,
    ERR_STUFF = 2'd2,
    ERR_OVF   = 2'd3
  } nrzi_err_t;

  localparam int SYNC_LEN  = 8;
  localparam int STUFF_RUN = 6;
  localparam int UNSTUFF_W = 6;
endpackage

// File: rtl/nrzi_dec_if.sv
// nrzi_dec_if: line side inputs and packet-stream outputs of nrzi_dec.
//   line_in, line_valid      : raw line level (J=1, K=0) and J/K-present flag
//   bstr_out, bstr_out_valid : decoded, unstuffed bit and its qualifier
//   pkt_start, pkt_end       : one-cycle framing pulses
//   rx_err, err_code         : abort pulse and its cause (held until next
//                              rx_err or pkt_start)
//   unstuffed                : stuffed bits removed in current/last packet
//   state                    : decoder FSM state, for observation
// Handshake: there is no back-pressure. A bit is transferred on every cycle
// where bstr_out_valid is high; the consumer must accept it that cycle.
// Modports: master = decoder, slave = line driver / packet parser.
interface nrzi_dec_if;
  import nrzi_pkg::*;

  logic            line_in;
  logic            line_valid;
  logic            bstr_out;
  logic            bstr_out_valid;
  logic            pkt_start;
  logic            pkt_end;
  logic            rx_err;
  logic [1:0]      err_code;
  logic [5:0]      unstuffed;
  nrzi_dec_state_t state;

  modport master (
    input  line_in, line_valid,
    output bstr_out, bstr_out_valid, pkt_start, pkt_end, rx_err,
           err_code, unstuffed, state
  );

  modport slave (
    output line_in, line_valid,
    input  bstr_out, bstr_out_valid, pkt_start, pkt_end, rx_err,
           err_code, unstuffed, state
  );
endinterface

// File: rtl/nrzi_unstuff.sv
// nrzi_unstuff: bit-unstuffing decision for the NRZI decoder.
//   clk, rst_b : clock, asynchronous active-high reset
//   clear      : restart counting (SYNC accepted)
//   bit_valid  : bit_in is a DATA-phase sample this cycle
//   bit_in     : decoded NRZI bit
//   discard    : current bit is a stuffed 0 and must be dropped (comb)
//   stuff_err  : seventh consecutive 1 seen (comb)
//   unstuffed  : saturating count of discarded bits since clear
module nrzi_unstuff
  import nrzi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 clear,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 discard,
  output logic                 stuff_err,
  output logic [UNSTUFF_W-1:0] unstuffed
);
  logic [2:0] ones;
  logic       run_full;

  assign run_full  = (ones == 3'(STUFF_RUN));
  assign discard   = bit_valid && run_full && !bit_in;
  assign stuff_err = bit_valid && run_full && bit_in;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ones      <= '0;
      unstuffed <= '0;
    end else if (clear) begin
      ones      <= '0;
      unstuffed <= '0;
    end else if (bit_valid) begin
      // A full run always resets: either the stuffed 0 is dropped or the
      // packet aborts, and the counter restarts on the next SYNC anyway.
      if (run_full || !bit_in) ones <= '0;
      else                     ones <= ones + 3'd1;
      if (discard && (unstuffed != {UNSTUFF_W{1'b1}}))
        unstuffed <= unstuffed + 1'b1;
    end
  end
endmodule

// File: rtl/nrzi_dec.sv
// nrzi_dec: USB receive NRZI decoder. Samples the line every clock, locks
// onto SYNC, decodes NRZI, removes stuffed bits and frames the packet.
//   clk   : sole clock, line sampled on every rising edge
//   rst_b : asynchronous, active-high reset
//   bus   : nrzi_dec_if.master (line inputs, packet outputs, FSM state)
// Parameter MAX_BITS: maximum unstuffed post-SYNC bits per packet.
// Build option NRZI_DEC_UNSTUFF_EN: when defined, stuffed bits are removed
// and STUFF errors raised; when undefined every decoded DATA bit is emitted
// and unstuffed reads 0. All outputs are registered (1-cycle latency).
module nrzi_dec
  import nrzi_pkg::*;
#(
  parameter int MAX_BITS = 88
) (
  input  logic       clk,
  input  logic       rst_b,
  nrzi_dec_if.master bus
);
  localparam int BW = $clog2(MAX_BITS + 1);

  nrzi_dec_state_t      state, state_n;
  nrzi_err_t            err_sel;
  logic                 prev, dec;
  logic [2:0]           zcnt;
  logic [BW-1:0]        bcnt;
  logic                 discard, stuff_err;
  logic [UNSTUFF_W-1:0] unstuffed_q;
  logic                 emit, start_d, end_d, err_d;
  nrzi_err_t            code_d;
  logic                 bstr_q, bstr_valid_q, start_q, end_q, err_q;
  nrzi_err_t            code_q;

  // No transition decodes as 1.
  assign dec = (bus.line_in == prev);

`ifdef NRZI_DEC_UNSTUFF_EN
  logic bit_valid;
  assign bit_valid = (state == ST_DATA) && bus.line_valid;

  nrzi_unstuff u_unstuff (
    .clk       (clk),
    .rst_b     (rst_b),
    .clear     (start_d),
    .bit_valid (bit_valid),
    .bit_in    (dec),
    .discard   (discard),
    .stuff_err (stuff_err),
    .unstuffed (unstuffed_q)
  );
`else
  assign discard     = 1'b0;
  assign stuff_err   = 1'b0;
  assign unstuffed_q = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; err_sel names the cause whenever ERR is entered.
  always_comb begin
    state_n = state;
    err_sel = ERR_NONE;
    case (state)
      ST_IDLE: if (bus.line_valid && !dec) state_n = ST_SYNC;
      ST_SYNC: begin
        if (!bus.line_valid) begin
          state_n = ST_IDLE;
        end else if (zcnt == 3'(SYNC_LEN - 1)) begin
          if (dec) state_n = ST_DATA;
          else begin
            state_n = ST_ERR;
            err_sel = ERR_SYNC;
          end
        end else if (dec) begin
          state_n = ST_ERR;
          err_sel = ERR_SYNC;
        end
      end
      ST_DATA: begin
        if (!bus.line_valid) begin
          state_n = ST_IDLE;
        end else if (stuff_err) begin
          state_n = ST_ERR;
          err_sel = ERR_STUFF;
        end else if (!discard && (bcnt == BW'(MAX_BITS))) begin
          state_n = ST_ERR;
          err_sel = ERR_OVF;
        end
      end
      ST_ERR:  if (!bus.line_valid) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output decode: all pulses are derived from the transition taken.
  always_comb begin
    start_d = (state == ST_SYNC) && (state_n == ST_DATA);
    end_d   = (state == ST_DATA) && (state_n == ST_IDLE);
    err_d   = (state != ST_ERR)  && (state_n == ST_ERR);
    emit    = (state == ST_DATA) && (state_n == ST_DATA) &&
              bus.line_valid && !discard;
    code_d  = code_q;
    if (start_d) code_d = ERR_NONE;
    if (err_d)   code_d = err_sel;
  end

  // Line history and SYNC / bit counters
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      prev <= 1'b1;
      zcnt <= '0;
      bcnt <= '0;
    end else begin
      prev <= bus.line_valid ? bus.line_in : 1'b1;
      if (state == ST_IDLE && state_n == ST_SYNC)      zcnt <= 3'd1;
      else if (state == ST_SYNC && state_n == ST_SYNC) zcnt <= zcnt + 3'd1;
      if (start_d)   bcnt <= '0;
      else if (emit) bcnt <= bcnt + 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      bstr_q       <= 1'b0;
      bstr_valid_q <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      bstr_q       <= emit && dec;
      bstr_valid_q <= emit;
      start_q      <= start_d;
      end_q        <= end_d;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  assign bus.bstr_out       = bstr_q;
  assign bus.bstr_out_valid = bstr_valid_q;
  assign bus.pkt_start      = start_q;
  assign bus.pkt_end        = end_q;
  assign bus.rx_err         = err_q;
  assign bus.err_code       = code_q;
  assign bus.unstuffed      = unstuffed_q;
  assign bus.state          = state;
endmodule
